// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flow controller: FSM encodings,
// register-address constants and the stall/flush control bundle.
package hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned FLUSH_CNT_W = 3;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_BRFLUSH = 2'd1,
    HZ_MEMWAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
  } hz_ctrl_t;

  // A load in EX whose non-zero rd feeds a source the ID instruction reads.
  function automatic logic load_use_hit(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  uses_rs2
  );
    return mem_read && (rd != REG_ZERO) &&
           ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters.
module hazard_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK_i,
  input  logic             RSTn_i,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flow controller: load-use stalls, taken-branch drains and
// memory-wait freezes for the IF/ID, ID/EX and EX/MEM latches.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  CLK_i,
  input  logic                  RSTn_i,
  input  logic [REG_ADDR_W-1:0] id_addrSrc1_i,
  input  logic [REG_ADDR_W-1:0] id_addrSrc2_i,
  input  logic                  id_usesSrc2_i,
  input  logic                  ex_memRead_i,
  input  logic [REG_ADDR_W-1:0] ex_regDest_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  output logic                  pc_stall_o,
  output logic                  ifid_stall_o,
  output logic                  ifid_flush_o,
  output logic                  idex_stall_o,
  output logic                  idex_flush_o,
  output logic                  exmem_stall_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  hz_state_e              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_rem_q, flush_rem_d;
  hz_ctrl_t               ctrl;
  logic                   flush_evt;
  logic                   mem_hold;
  logic                   load_use;

  assign load_use = load_use_hit(ex_memRead_i, ex_regDest_i, id_addrSrc1_i,
                                 id_addrSrc2_i, id_usesSrc2_i);

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state_q     <= HZ_RUN;
      flush_rem_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_rem_q <= flush_rem_d;
    end
  end

  // A memory hold freezes everything, including any pending flush count.
  always_comb begin
    state_d     = (state_q == HZ_BRFLUSH) ? HZ_BRFLUSH : HZ_RUN;
    flush_rem_d = flush_rem_q;
    ctrl        = '0;
    flush_evt   = 1'b0;
    mem_hold    = (state_q == HZ_MEMWAIT) ? !mem_ready_i
                                          : (mem_req_i && !mem_ready_i);

    if (mem_hold) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_stall  = 1'b1;
      ctrl.exmem_stall = 1'b1;
      state_d          = HZ_MEMWAIT;
    end else begin
      if (state_q == HZ_MEMWAIT) begin
        state_d = (flush_rem_q != '0) ? HZ_BRFLUSH : HZ_RUN;
      end
      if (branch_taken_i) begin
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_flush = 1'b1;
        flush_evt       = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          flush_rem_d = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
          state_d     = HZ_BRFLUSH;
        end else begin
          flush_rem_d = '0;
          state_d     = HZ_RUN;
        end
      end else if (state_q == HZ_BRFLUSH) begin
        ctrl.ifid_flush = 1'b1;
        flush_rem_d     = flush_rem_q - FLUSH_CNT_W'(1);
        state_d         = (flush_rem_q <= FLUSH_CNT_W'(1)) ? HZ_RUN : HZ_BRFLUSH;
      end else if (load_use) begin
        ctrl.pc_stall   = 1'b1;
        ctrl.ifid_stall = 1'b1;
        ctrl.idex_flush = 1'b1;
      end
    end
  end

  assign pc_stall_o    = RSTn_i & ctrl.pc_stall;
  assign ifid_stall_o  = RSTn_i & ctrl.ifid_stall;
  assign ifid_flush_o  = RSTn_i & ctrl.ifid_flush;
  assign idex_stall_o  = RSTn_i & ctrl.idex_stall;
  assign idex_flush_o  = RSTn_i & ctrl.idex_flush;
  assign exmem_stall_o = RSTn_i & ctrl.exmem_stall;

  hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK_i  (CLK_i),
    .RSTn_i (RSTn_i),
    .inc    (pc_stall_o),
    .count  (stall_cnt_o)
  );

  hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK_i  (CLK_i),
    .RSTn_i (RSTn_i),
    .inc    (flush_evt & RSTn_i),
    .count  (flush_cnt_o)
  );

endmodule
